// File: rtl/program_loader.sv
// program_loader: boot-time image loader in front of the CPU main memory.
// It streams 32-bit words into consecutive addresses starting at BASE_ADDR
// and holds the CPU in reset until the last write has been committed.
// Optional feature macro: LOADER_CLEAR_EN. When it is defined, the memory
// left after the image (up to BASE_ADDR+DEPTH-1) is zero-filled before release.
module program_loader #(
    parameter int          DEPTH     = 2048,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic        cpu_hold,
    output logic        done,
    output logic        overflow,
    output logic [31:0] word_count,
    output logic [31:0] checksum
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(DEPTH) - 32'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr;
    logic        xfer;
    logic        at_last;
    logic        release_cpu;

    assign in_ready    = (state == LOAD);
    assign xfer        = in_valid & in_ready;
    assign at_last     = (addr == LAST_ADDR);
    // A start seen in DONE re-arms the hold on the same edge it restarts the load.
    assign release_cpu = (state == DONE) && !start;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD: begin
                if (xfer) begin
                    if (in_last) begin
`ifdef LOADER_CLEAR_EN
                        state_nxt = at_last ? DONE : CLEAR;
`else
                        state_nxt = DONE;
`endif
                    end else if (at_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            CLEAR: if (at_last) state_nxt = DONE;
            DONE:  if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // State, address counter, registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            addr       <= BASE_ADDR;
            mem_waddr  <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_wen    <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= 32'd0;
            checksum   <= 32'd0;
        end else begin
            state    <= state_nxt;
            mem_wen  <= 1'b0;
            done     <= release_cpu;
            cpu_hold <= !release_cpu;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        addr       <= BASE_ADDR;
                        word_count <= 32'd0;
                        checksum   <= 32'd0;
                        overflow   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        mem_waddr  <= addr;
                        mem_wdata  <= in_data;
                        mem_wen    <= 1'b1;
                        addr       <= addr + 32'd1;
                        word_count <= word_count + 32'd1;
                        checksum   <= checksum + in_data;
                        // Word at the last address without in_last: image too big.
                        if (at_last && !in_last) overflow <= 1'b1;
                    end
                end
                CLEAR: begin
                    mem_waddr <= addr;
                    mem_wdata <= 32'd0;
                    mem_wen   <= 1'b1;
                    addr      <= addr + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with DEPTH=8, BASE_ADDR=0.
module tb_program_loader;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        cpu_hold;
    logic        done;
    logic        overflow;
    logic [31:0] word_count;
    logic [31:0] checksum;

    int tests = 0;
    int fails = 0;

    program_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'd0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
        .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s, v;
        logic [31:0] d;
        logic        l;
        logic        rdy, wen;
        logic [31:0] a, wd;
        logic        hold, dn;
        logic [31:0] cnt, sum;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive inputs for one edge, then sample 1 time unit after that edge.
    task automatic cyc(input logic s, input logic v, input logic [31:0] d, input logic l);
        start = s; in_valid = v; in_data = d; in_last = l;
        @(posedge clk);
        #1;
    endtask

    // Run idle cycles until done, checking any zero-fill writes starting at n.
    task automatic wait_done(input int n);
        int   zc;
        int   na;
        int   exp_z;
        logic pw;
        zc = 0;
        na = n;
        pw = mem_wen;
`ifdef LOADER_CLEAR_EN
        exp_z = DEPTH - n;
`else
        exp_z = 0;
`endif
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, 1'b0, 32'd0, 1'b0);
            if (done) begin
                chk("write_before_done", {31'd0, pw}, 32'd1);
                chk("no_wen_at_done", {31'd0, mem_wen}, 32'd0);
                chk("hold_released", {31'd0, cpu_hold}, 32'd0);
                chk("zero_fill_count", zc, exp_z);
                return;
            end
            if (mem_wen) begin
                chk("clear_addr", mem_waddr, na);
                chk("clear_data", mem_wdata, 32'd0);
                na++;
                zc++;
            end
            pw = mem_wen;
        end
        fails++;
        $display("FAIL done_timeout: done never rose within 40 cycles");
    endtask

    initial begin
        //           s     v     d              l     rdy   wen   a      wd     hold  dn    cnt    sum
        tbl[0] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0};
        tbl[1] = '{1'b0, 1'b1, 32'h1,        1'b0, 1'b1, 1'b1, 32'd0, 32'd1, 1'b1, 1'b0, 32'd1, 32'd1};
        tbl[2] = '{1'b0, 1'b0, 32'h99,       1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd1, 32'd1};
        tbl[3] = '{1'b1, 1'b1, 32'h2,        1'b0, 1'b1, 1'b1, 32'd1, 32'd2, 1'b1, 1'b0, 32'd2, 32'd3};
        tbl[4] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd2, 32'd3};
        tbl[5] = '{1'b0, 1'b1, 32'h3,        1'b0, 1'b1, 1'b1, 32'd2, 32'd3, 1'b1, 1'b0, 32'd3, 32'd6};
        tbl[6] = '{1'b0, 1'b1, 32'h4,        1'b1, 1'b0, 1'b1, 32'd3, 32'd4, 1'b1, 1'b0, 32'd4, 32'd10};

        // Reset values
        rst = 1'b0;
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'd5, 1'b0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_waddr", mem_waddr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_count", word_count, 32'd0);
        chk("rst_sum", checksum, 32'd0);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 32'd5, 1'b0);
        chk("idle_no_accept", {31'd0, in_ready | mem_wen}, 32'd0);

        // 4-word image with valid gaps; start mid-load is ignored (row 3)
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].l);
            chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("v%0d_wen", i), {31'd0, mem_wen}, {31'd0, tbl[i].wen});
            if (tbl[i].wen) begin
                chk($sformatf("v%0d_waddr", i), mem_waddr, tbl[i].a);
                chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wd);
            end
            chk($sformatf("v%0d_hold", i), {31'd0, cpu_hold}, {31'd0, tbl[i].hold});
            chk($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, tbl[i].dn});
            chk($sformatf("v%0d_count", i), word_count, tbl[i].cnt);
            chk($sformatf("v%0d_sum", i), checksum, tbl[i].sum);
        end
        wait_done(4);
        chk("img1_count", word_count, 32'd4);
        chk("img1_sum", checksum, 32'hA);
        chk("img1_ovf", {31'd0, overflow}, 32'd0);

        // Restart from DONE; checksum wraps
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_ready", {31'd0, in_ready}, 32'd1);
        chk("restart_count", word_count, 32'd0);
        chk("restart_sum", checksum, 32'd0);
        cyc(1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
        chk("wrap_a0", mem_waddr, 32'd0);
        chk("wrap_sum0", checksum, 32'hFFFFFFFF);
        cyc(1'b0, 1'b1, 32'h2, 1'b1);
        chk("wrap_a1", mem_waddr, 32'd1);
        chk("wrap_sum1", checksum, 32'h1);
        wait_done(2);
        chk("wrap_count", word_count, 32'd2);
        chk("wrap_final_sum", checksum, 32'h1);

        // Overflow: 10 words, no in_last
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, i + 1, 1'b0);
            if (i < DEPTH) begin
                chk($sformatf("ovf_wen%0d", i), {31'd0, mem_wen}, 32'd1);
                chk($sformatf("ovf_addr%0d", i), mem_waddr, i);
            end else begin
                chk($sformatf("ovf_nowen%0d", i), {31'd0, mem_wen}, 32'd0);
                chk($sformatf("ovf_noready%0d", i), {31'd0, in_ready}, 32'd0);
            end
        end
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_count", word_count, 32'd8);
        chk("ovf_sum", checksum, 32'd36);
        chk("ovf_done", {31'd0, done}, 32'd1);

        // Reset mid-load after 2 of 4 words
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'd7, 1'b0);
        cyc(1'b0, 1'b1, 32'd8, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 32'd9, 1'b0);
        chk("mid_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_wen", {31'd0, mem_wen}, 32'd0);
        chk("mid_waddr", mem_waddr, 32'd0);
        chk("mid_wdata", mem_wdata, 32'd0);
        chk("mid_hold", {31'd0, cpu_hold}, 32'd1);
        chk("mid_done", {31'd0, done}, 32'd0);
        chk("mid_ovf", {31'd0, overflow}, 32'd0);
        chk("mid_count", word_count, 32'd0);
        chk("mid_sum", checksum, 32'd0);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 32'd5, 1'b1);
        chk("reload_addr", mem_waddr, 32'd0);
        chk("reload_data", mem_wdata, 32'd5);
        chk("reload_count", word_count, 32'd1);
        chk("reload_sum", checksum, 32'd5);
        wait_done(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
